// File: rtl/wbq_pkg.sv
// Shared constants and queue-entry type for the write-back queue.
package wbq_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wbq_entry_t;

endpackage

// File: rtl/wbq_lookup.sv
// Bypass search: returns the youngest valid entry matching i_raddr,
// scanning backwards from the write pointer. Address 0 never hits.
module wbq_lookup
   import wbq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  wbq_entry_t                 i_entries [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]   i_wptr,
   input  logic [AW-1:0]              i_raddr,
   output logic                       o_hit,
   output logic [DW-1:0]              o_data
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] w_idx;

   // Oldest-to-youngest walk: later matches overwrite earlier ones.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      w_idx  = '0;
      for (int unsigned k = DEPTH; k >= 1; k--) begin
         w_idx = i_wptr - PW'(k);
         if (i_entries[w_idx].valid &&
             i_entries[w_idx].addr == REG_ADDR_W'(i_raddr)) begin
            o_hit  = 1'b1;
            o_data = DW'(i_entries[w_idx].data);
         end
      end
      if (REG_ADDR_W'(i_raddr) == ZERO_REG) begin
         o_hit  = 1'b0;
         o_data = '0;
      end
   end

endmodule

// File: rtl/wb_queue.sv
// In-order write-back queue feeding the regfile write port, with two
// bypass lookup ports. Optional WBQ_COALESCE_EN merges same-register pushes.
module wb_queue
   import wbq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     InValid,
   output logic                     InReady,
   input  logic [AW-1:0]            InRegister,
   input  logic [DW-1:0]            InData,
   input  logic                     WbStall,
   output logic                     RegWrite,
   output logic [AW-1:0]            WriteRegister,
   output logic [DW-1:0]            WriteData,
   input  logic [AW-1:0]            ReadRegister1,
   input  logic [AW-1:0]            ReadRegister2,
   output logic                     Hit1,
   output logic [DW-1:0]            HitData1,
   output logic                     Hit2,
   output logic [DW-1:0]            HitData2,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wbq_entry_t    r_q [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   logic          w_acc;
   logic          w_pop;
   logic          w_nonzero;
   logic          w_alloc;
   logic          w_coal;
   logic          w_hit1;
   logic          w_hit2;
   logic [DW-1:0] w_hd1;
   logic [DW-1:0] w_hd2;

   assign Count     = r_count;
   assign InReady   = !Reset && (r_count < CW'(DEPTH));
   assign w_pop     = !Reset && (r_count != '0) && !WbStall;
   assign RegWrite  = w_pop;
   assign w_acc     = InValid && InReady;
   assign w_nonzero = (REG_ADDR_W'(InRegister) != ZERO_REG);

   assign WriteRegister = (r_count != '0) ? AW'(r_q[r_rptr].addr) : '0;
   assign WriteData     = (r_count != '0) ? DW'(r_q[r_rptr].data) : '0;

`ifdef WBQ_COALESCE_EN
   logic [PW-1:0] w_yidx;
   assign w_yidx = r_wptr - PW'(1);
   // A head that pops this edge cannot absorb the push; it must allocate.
   assign w_coal = w_acc && w_nonzero && (r_count != '0) &&
                   r_q[w_yidx].valid &&
                   (r_q[w_yidx].addr == REG_ADDR_W'(InRegister)) &&
                   !(w_pop && (w_yidx == r_rptr));
`else
   assign w_coal = 1'b0;
`endif

   assign w_alloc = w_acc && w_nonzero && !w_coal;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_q[i] <= '0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_pop) begin
            r_q[r_rptr].valid <= 1'b0;
            r_rptr            <= r_rptr + PW'(1);
         end
         if (w_alloc) begin
            r_q[r_wptr].valid <= 1'b1;
            r_q[r_wptr].addr  <= REG_ADDR_W'(InRegister);
            r_q[r_wptr].data  <= REG_DATA_W'(InData);
            r_wptr            <= r_wptr + PW'(1);
         end
`ifdef WBQ_COALESCE_EN
         if (w_coal) begin
            r_q[w_yidx].data <= REG_DATA_W'(InData);
         end
`endif
         r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
      end
   end

   wbq_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_lookup1 (
      .i_entries (r_q),
      .i_wptr    (r_wptr),
      .i_raddr   (ReadRegister1),
      .o_hit     (w_hit1),
      .o_data    (w_hd1)
   );

   wbq_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_lookup2 (
      .i_entries (r_q),
      .i_wptr    (r_wptr),
      .i_raddr   (ReadRegister2),
      .o_hit     (w_hit2),
      .o_data    (w_hd2)
   );

   assign Hit1     = !Reset && w_hit1;
   assign HitData1 = Hit1 ? w_hd1 : '0;
   assign Hit2     = !Reset && w_hit2;
   assign HitData2 = Hit2 ? w_hd2 : '0;

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (default DEPTH=4, AW=5, DW=32);
// expected Count in the coalesce scenario follows WBQ_COALESCE_EN.
module tb_wb_queue;

   logic        Clk;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [4:0]  InRegister;
   logic [31:0] InData;
   logic        WbStall;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic        Hit1;
   logic [31:0] HitData1;
   logic        Hit2;
   logic [31:0] HitData2;
   logic [2:0]  Count;

   int n_tests = 0;
   int n_fail  = 0;

   wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .InValid       (InValid),
      .InReady       (InReady),
      .InRegister    (InRegister),
      .InData        (InData),
      .WbStall       (WbStall),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .Hit1          (Hit1),
      .HitData1      (HitData1),
      .Hit2          (Hit2),
      .HitData2      (HitData2),
      .Count         (Count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; InValid = 1'b1; InRegister = 5'd3; InData = 32'h5;
      WbStall = 1'b0; ReadRegister1 = 5'd3; ReadRegister2 = 5'd0;
      tick(); tick();
      n_tests++; if (Count !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", Count); end
      n_tests++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL rst_inready got=%0b exp=0", InReady); end
      n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL rst_regwrite got=%0b exp=0", RegWrite); end
      n_tests++; if (Hit1 !== 1'b0) begin n_fail++; $display("FAIL rst_hit1 got=%0b exp=0", Hit1); end
      InValid = 1'b0;
      Reset = 1'b0;
      #1;
      n_tests++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL rst_inready_after got=%0b exp=1", InReady); end
      n_tests++; if (WriteRegister !== 5'd0 || WriteData !== 32'd0) begin n_fail++; $display("FAIL rst_wdata got=%0d/%0h exp=0/0", WriteRegister, WriteData); end
   endtask

   task automatic test_single();
      InValid = 1'b1; InRegister = 5'd5; InData = 32'hDEADBEEF; WbStall = 1'b0;
      #1;
      n_tests++; if (RegWrite !== 1'b0 || WriteData !== 32'd0) begin n_fail++; $display("FAIL single_no_comb got=%0b/%0h exp=0/0", RegWrite, WriteData); end
      tick();
      InValid = 1'b0; ReadRegister1 = 5'd5;
      #1;
      n_tests++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL single_regwrite got=%0b exp=1", RegWrite); end
      n_tests++; if (WriteRegister !== 5'd5) begin n_fail++; $display("FAIL single_wreg got=%0d exp=5", WriteRegister); end
      n_tests++; if (WriteData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wdata got=%0h exp=deadbeef", WriteData); end
      n_tests++; if (Count !== 3'd1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", Count); end
      n_tests++; if (Hit1 !== 1'b1 || HitData1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_head_hit got=%0b/%0h exp=1/deadbeef", Hit1, HitData1); end
      tick();
      n_tests++; if (Count !== 3'd0) begin n_fail++; $display("FAIL single_count_after got=%0d exp=0", Count); end
      n_tests++; if (RegWrite !== 1'b0 || WriteRegister !== 5'd0) begin n_fail++; $display("FAIL single_empty got=%0b/%0d exp=0/0", RegWrite, WriteRegister); end
      n_tests++; if (Hit1 !== 1'b0 || HitData1 !== 32'd0) begin n_fail++; $display("FAIL single_hit_gone got=%0b/%0h exp=0/0", Hit1, HitData1); end
   endtask

   task automatic test_full_stall();
      WbStall = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         InValid = 1'b1; InRegister = 5'(i); InData = 32'(i * 17);
         tick();
      end
      InRegister = 5'd5; InData = 32'h55;
      #1;
      n_tests++; if (Count !== 3'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", Count); end
      n_tests++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL full_inready got=%0b exp=0", InReady); end
      n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL full_regwrite got=%0b exp=0", RegWrite); end
      tick();
      InValid = 1'b0;
      n_tests++; if (Count !== 3'd4) begin n_fail++; $display("FAIL full_fifth_rejected got=%0d exp=4", Count); end
      WbStall = 1'b0;
      #1;
      for (int i = 1; i <= 4; i++) begin
         n_tests++;
         if (RegWrite !== 1'b1 || WriteRegister !== 5'(i) || WriteData !== 32'(i * 17)) begin
            n_fail++;
            $display("FAIL full_drain_%0d got=%0b/%0d/%0h exp=1/%0d/%0h", i, RegWrite, WriteRegister, WriteData, i, i * 17);
         end
         tick();
      end
      n_tests++; if (Count !== 3'd0 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL full_drained got=%0d/%0b exp=0/0", Count, RegWrite); end
   endtask

   task automatic test_coalesce();
      logic [2:0]  exp_cnt;
      logic [31:0] exp_first;
`ifdef WBQ_COALESCE_EN
      exp_cnt = 3'd1; exp_first = 32'hB;
`else
      exp_cnt = 3'd2; exp_first = 32'hA;
`endif
      WbStall = 1'b1; ReadRegister1 = 5'd7;
      InValid = 1'b1; InRegister = 5'd7; InData = 32'hA;
      tick();
      InData = 32'hB;
      tick();
      InValid = 1'b0;
      #1;
      n_tests++; if (Hit1 !== 1'b1 || HitData1 !== 32'hB) begin n_fail++; $display("FAIL coal_hit got=%0b/%0h exp=1/b", Hit1, HitData1); end
      n_tests++; if (Count !== exp_cnt) begin n_fail++; $display("FAIL coal_count got=%0d exp=%0d", Count, exp_cnt); end
      WbStall = 1'b0;
      #1;
      n_tests++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || WriteData !== exp_first) begin n_fail++; $display("FAIL coal_first_write got=%0b/%0d/%0h exp=1/7/%0h", RegWrite, WriteRegister, WriteData, exp_first); end
      tick(); tick();
      n_tests++; if (Count !== 3'd0) begin n_fail++; $display("FAIL coal_drained got=%0d exp=0", Count); end
   endtask

   task automatic test_zero_reg();
      WbStall = 1'b0; ReadRegister2 = 5'd0;
      InValid = 1'b1; InRegister = 5'd0; InData = 32'h1234;
      #1;
      n_tests++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL zero_inready got=%0b exp=1", InReady); end
      tick();
      InValid = 1'b0;
      #1;
      n_tests++; if (Count !== 3'd0 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL zero_dropped got=%0d/%0b exp=0/0", Count, RegWrite); end
      n_tests++; if (Hit2 !== 1'b0 || HitData2 !== 32'd0) begin n_fail++; $display("FAIL zero_hit2 got=%0b/%0h exp=0/0", Hit2, HitData2); end
      tick();
      n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL zero_no_write got=%0b exp=0", RegWrite); end
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp_order [3];
      exp_order[0] = 5'd3; exp_order[1] = 5'd4; exp_order[2] = 5'd6;
      WbStall = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         InValid = 1'b1; InRegister = 5'(i); InData = 32'(256 + i);
         tick();
      end
      WbStall = 1'b0; InRegister = 5'd6; InData = 32'h66;
      #1;
      n_tests++; if (InReady !== 1'b0 || RegWrite !== 1'b1 || WriteRegister !== 5'd1) begin n_fail++; $display("FAIL b2b_full_pop got=%0b/%0b/%0d exp=0/1/1", InReady, RegWrite, WriteRegister); end
      tick();
      n_tests++; if (Count !== 3'd3 || InReady !== 1'b1) begin n_fail++; $display("FAIL b2b_after_pop got=%0d/%0b exp=3/1", Count, InReady); end
      n_tests++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd2) begin n_fail++; $display("FAIL b2b_push_pop got=%0b/%0d exp=1/2", RegWrite, WriteRegister); end
      tick();
      InValid = 1'b0; ReadRegister1 = 5'd6;
      #1;
      n_tests++; if (Count !== 3'd3) begin n_fail++; $display("FAIL b2b_count_kept got=%0d exp=3", Count); end
      n_tests++; if (Hit1 !== 1'b1 || HitData1 !== 32'h66) begin n_fail++; $display("FAIL b2b_hit_wrap got=%0b/%0h exp=1/66", Hit1, HitData1); end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (RegWrite !== 1'b1 || WriteRegister !== exp_order[i]) begin
            n_fail++;
            $display("FAIL b2b_order_%0d got=%0b/%0d exp=1/%0d", i, RegWrite, WriteRegister, exp_order[i]);
         end
         tick();
      end
      // Head pops while a same-register push arrives: must allocate in both builds.
      InValid = 1'b1; InRegister = 5'd9; InData = 32'h1;
      tick();
      InData = 32'h2;
      #1;
      n_tests++; if (RegWrite !== 1'b1 || WriteData !== 32'h1) begin n_fail++; $display("FAIL b2b_head_pop got=%0b/%0h exp=1/1", RegWrite, WriteData); end
      tick();
      InValid = 1'b0;
      #1;
      n_tests++; if (Count !== 3'd1 || WriteRegister !== 5'd9 || WriteData !== 32'h2) begin n_fail++; $display("FAIL b2b_realloc got=%0d/%0d/%0h exp=1/9/2", Count, WriteRegister, WriteData); end
      tick();
      n_tests++; if (Count !== 3'd0) begin n_fail++; $display("FAIL b2b_drained got=%0d exp=0", Count); end
   endtask

   task automatic test_reset_mid();
      WbStall = 1'b1; ReadRegister1 = 5'd10; ReadRegister2 = 5'd12;
      for (int i = 10; i <= 12; i++) begin
         InValid = 1'b1; InRegister = 5'(i); InData = 32'(i);
         tick();
      end
      InValid = 1'b0;
      #1;
      n_tests++; if (Count !== 3'd3 || Hit1 !== 1'b1 || Hit2 !== 1'b1) begin n_fail++; $display("FAIL rmid_pending got=%0d/%0b/%0b exp=3/1/1", Count, Hit1, Hit2); end
      WbStall = 1'b0; Reset = 1'b1;
      #1;
      n_tests++; if (RegWrite !== 1'b0 || Hit1 !== 1'b0 || Hit2 !== 1'b0 || InReady !== 1'b0) begin n_fail++; $display("FAIL rmid_during got=%0b/%0b/%0b/%0b exp=0/0/0/0", RegWrite, Hit1, Hit2, InReady); end
      tick();
      Reset = 1'b0;
      #1;
      n_tests++; if (Count !== 3'd0 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL rmid_after got=%0d/%0b exp=0/0", Count, RegWrite); end
      n_tests++; if (Hit1 !== 1'b0 || Hit2 !== 1'b0) begin n_fail++; $display("FAIL rmid_hits got=%0b/%0b exp=0/0", Hit1, Hit2); end
      tick();
      n_tests++; if (RegWrite !== 1'b0 || Count !== 3'd0) begin n_fail++; $display("FAIL rmid_stale got=%0b/%0d exp=0/0", RegWrite, Count); end
   endtask

   initial begin
      Reset = 1'b1; InValid = 1'b0; InRegister = '0; InData = '0;
      WbStall = 1'b0; ReadRegister1 = '0; ReadRegister2 = '0;
      test_reset();
      test_single();
      test_full_stall();
      test_coalesce();
      test_zero_reg();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back queue sitting directly upstream of the MIPS register file's single write port.
- Buffers register-write requests from execute/memory stages in a small in-order FIFO and drains one per cycle onto WriteRegister/WriteData/RegWrite.
- Provides two bypass lookup ports so operand reads see pending, not-yet-committed values. Downstream operand muxing selects HitData over regfile ReadData on a hit.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >= 2)
- AW, 5, register address width
- DW, 32, register data width

Ports:
- Clk  in  1  clock, positive edge
- Reset  in  1  synchronous, active-high reset
- InValid  in  1  write request valid
- InReady  out  1  queue can accept a request
- InRegister  in  AW  destination register of the request
- InData  in  DW  data of the request
- WbStall  in  1  regfile write port unavailable this cycle
- RegWrite  out  1  to regfile write enable
- WriteRegister  out  AW  to regfile write address
- WriteData  out  DW  to regfile write data
- ReadRegister1  in  AW  bypass lookup address, port 1
- ReadRegister2  in  AW  bypass lookup address, port 2
- Hit1  out  1  port 1 has a pending queued value
- HitData1  out  DW  youngest pending value for ReadRegister1
- Hit2  out  1  port 2 has a pending queued value
- HitData2  out  DW  youngest pending value for ReadRegister2
- Count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Clock and reset: one clock (Clk). Reset is synchronous and active-high.
- Reset state:
  - Count=0; read and write pointers = 0; entries invalid.
  - While Reset is high: RegWrite=0, InReady=0, Hit1/Hit2=0.
  - Pending entries are discarded; a reset mid-drain issues no write.
- Handshake:
  - InReady = !Reset && (Count < DEPTH). It does not depend on a same-cycle pop.
  - Transfer occurs on a posedge with InValid && InReady.
  - InRegister==0 is accepted and dropped (not enqueued, Count unchanged).
- Drain:
  - RegWrite = !Reset && Count!=0 && !WbStall.
  - WriteRegister/WriteData = head entry, driven combinationally from queue storage.
  - Head pops on the posedge where RegWrite=1.
  - WriteRegister/WriteData = 0 when the queue is empty.
- Latency: a request accepted at edge N appears on RegWrite in cycle N+1 at the earliest (empty queue, no stall). There is no combinational InData-to-WriteData path.
- Simultaneous push and pop: Count unchanged; both pointers advance modulo DEPTH.
- Full: InReady=0. A pop in that cycle raises InReady the following cycle.
- WbStall: holds the head; entries and order are unchanged; pushes continue until full.
- Bypass lookup (combinational from queue state):
  - Scan all valid entries; the youngest entry whose address == ReadRegister wins.
  - Hit=0 when ReadRegister==0. HitData=0 when there is no hit.
  - The head being written this cycle still counts as a hit. The regfile updates at the same edge, so there is no visibility gap.
  - Same-cycle InData is not bypassed.
- Pointer wrap: pointers are AW-independent counters of $clog2(DEPTH) bits and wrap naturally.

Optional Feature:
- Macro: WBQ_COALESCE_EN.
- Defined: a push whose InRegister equals the youngest valid entry's address overwrites that entry's data in place; Count is unchanged.
  - The overwrite is suppressed if that entry is the head and pops this cycle. In that case a new entry is allocated.
  - InReady still follows Count < DEPTH.
- Undefined: every non-zero push allocates a new entry.

Decomposition:
- Shared package wbq_pkg:
  - constants REG_ADDR_W=5, REG_DATA_W=32, ZERO_REG=0
  - typedef wbq_entry_t {valid, addr[AW], data[DW]}
- Sub-module: wbq_lookup (youngest-match priority search over the entry array relative to the write pointer), instantiated twice, once per bypass port.

Test Plan:
- Reset, then push (r5, 0xDEADBEEF) with WbStall=0 -> next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; Count returns to 0 the cycle after.
- WbStall=1, push r1..r4 with data 0x11..0x44 -> Count=4, InReady=0, RegWrite=0; a fifth push is not accepted. Release WbStall -> writes r1..r4 in order, one per cycle.
- WbStall=1, push (r7, 0xA) then (r7, 0xB); ReadRegister1=7 -> Hit1=1, HitData1=0xB. With WBQ_COALESCE_EN defined -> Count=1; undefined -> Count=2.
- Push (r0, 0x1234) -> InReady handshake completes, Count stays 0, RegWrite never asserts. ReadRegister2=0 -> Hit2=0.
- Full queue plus InValid=1 with a concurrent pop -> no push that cycle; InReady=1 next cycle; push-and-pop together keeps Count=3 and preserves order.
- Three entries pending, Reset asserted for one cycle -> RegWrite=0 during reset; afterwards Count=0, Hit1=Hit2=0, and no stale writes are issued.
